// File: rtl/icache_fetch_port_pkg.sv
// Shared constants and types for the fetch-side instruction cache.
package icache_fetch_port_pkg;

    localparam int unsigned INDEX_BITS = 8;
    localparam int unsigned ADDR_BITS  = 32;
    localparam int unsigned WORD_LSB   = 2;
    localparam int unsigned WORD_BITS  = 32;
    localparam int unsigned TAG_BITS   = ADDR_BITS - INDEX_BITS - WORD_LSB;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_e;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data line arrays: one registered read port, one write port.
// A same-cycle write and read of one index returns the pre-write contents.
module icache_line_store #(
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned TAG_BITS   = 22
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       rd_en_i,
    input  logic [INDEX_BITS-1:0]                      rd_idx_i,
    output logic                                       rd_valid_o,
    output logic [TAG_BITS-1:0]                        rd_tag_o,
    output logic [icache_fetch_port_pkg::WORD_BITS-1:0] rd_data_o,
    input  logic                                       wr_en_i,
    input  logic [INDEX_BITS-1:0]                      wr_idx_i,
    input  logic [TAG_BITS-1:0]                        wr_tag_i,
    input  logic [icache_fetch_port_pkg::WORD_BITS-1:0] wr_data_i
);
    import icache_fetch_port_pkg::*;

    localparam int unsigned LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [WORD_BITS-1:0] data_q [LINES];

    logic                 rd_valid_q;
    logic [TAG_BITS-1:0]  rd_tag_q;
    logic [WORD_BITS-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_tag_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            if (wr_en_i) begin
                valid_q[wr_idx_i] <= 1'b1;
            end
            if (rd_en_i) begin
                rd_valid_q <= valid_q[rd_idx_i];
                rd_tag_q   <= tag_q[rd_idx_i];
                rd_data_q  <= data_q[rd_idx_i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_tag_o   = rd_tag_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/icache_fetch_port.sv
// Direct-mapped one-word-per-line instruction cache sitting in front of fetch.
// Hit result appears the cycle after lookup; misses fill one word from memory.
module icache_fetch_port #(
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned ADDR_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic [ADDR_BITS-1:0] fetch_pc,
    input  logic                 flush,
    input  logic [ADDR_BITS-1:0] flush_pc,
    output logic                 instr_valid,
    output logic [31:0]          instr,
    output logic [ADDR_BITS-1:0] instr_pc,
    output logic                 mem_req,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic                 mem_done,
    input  logic [31:0]          mem_data
);
    import icache_fetch_port_pkg::*;

    localparam int unsigned TAG_W = ADDR_BITS - INDEX_BITS - WORD_LSB;

    state_e state_q, state_d;
    logic   look_q, look_d;
    logic   byp_q, byp_d;
    logic   drop_q, drop_d;
    logic   redir_q, redir_d;
    logic [ADDR_BITS-1:0] lookup_pc_q, lookup_pc_d;
    logic [ADDR_BITS-1:0] miss_pc_q, miss_pc_d;
    logic [ADDR_BITS-1:0] redirect_pc_q, redirect_pc_d;
    logic [31:0]          byp_data_q, byp_data_d;

    logic                 rd_en, wr_en, rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [31:0]          rd_data;
    logic                 hit, in_miss, drop_cur;
    logic [ADDR_BITS-1:0] la, cur_miss_pc;

    icache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_W)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .rd_en_i    (rd_en && rdy),
        .rd_idx_i   (la[INDEX_BITS+1:WORD_LSB]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en && rdy),
        .wr_idx_i   (cur_miss_pc[INDEX_BITS+1:WORD_LSB]),
        .wr_tag_i   (cur_miss_pc[ADDR_BITS-1:INDEX_BITS+2]),
        .wr_data_i  (mem_data)
    );

    // The cycle a lookup resolves as a miss already behaves as MISS, so the
    // request, flush capture and fill can all start there.
    always_comb begin
        hit         = look_q && rd_valid && (rd_tag == lookup_pc_q[ADDR_BITS-1:INDEX_BITS+2]);
        in_miss     = (state_q == MISS) || (look_q && !hit);
        cur_miss_pc = (state_q == MISS) ? miss_pc_q : lookup_pc_q;
        drop_cur    = (state_q == MISS) && drop_q;
        la          = flush ? flush_pc : (redir_q ? redirect_pc_q : fetch_pc);

        instr_valid = byp_q || hit;
        instr       = byp_q ? byp_data_q : (hit ? rd_data : '0);
        instr_pc    = byp_q ? miss_pc_q : lookup_pc_q;
        mem_req     = in_miss;
        mem_addr    = {cur_miss_pc[ADDR_BITS-1:WORD_LSB], {WORD_LSB{1'b0}}};
    end

    always_comb begin
        state_d       = state_q;
        look_d        = 1'b0;
        byp_d         = 1'b0;
        drop_d        = drop_q;
        redir_d       = redir_q;
        lookup_pc_d   = lookup_pc_q;
        miss_pc_d     = miss_pc_q;
        redirect_pc_d = redirect_pc_q;
        byp_data_d    = byp_data_q;
        rd_en         = 1'b0;
        wr_en         = 1'b0;

        if (in_miss) begin
            state_d   = MISS;
            miss_pc_d = cur_miss_pc;
            drop_d    = drop_cur || flush;
            if (flush) begin
                redirect_pc_d = flush_pc;
            end
            if (mem_done) begin
                wr_en   = 1'b1;
                state_d = IDLE;
                drop_d  = 1'b0;
                if (drop_cur || flush) begin
                    redir_d = 1'b1;
                end else begin
                    byp_d      = 1'b1;
                    byp_data_d = mem_data;
                end
            end
        end else begin
            rd_en       = 1'b1;
            look_d      = 1'b1;
            lookup_pc_d = la;
            redir_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            look_q        <= 1'b0;
            byp_q         <= 1'b0;
            drop_q        <= 1'b0;
            redir_q       <= 1'b0;
            lookup_pc_q   <= '0;
            miss_pc_q     <= '0;
            redirect_pc_q <= '0;
            byp_data_q    <= '0;
        end else if (rdy) begin
            state_q       <= state_d;
            look_q        <= look_d;
            byp_q         <= byp_d;
            drop_q        <= drop_d;
            redir_q       <= redir_d;
            lookup_pc_q   <= lookup_pc_d;
            miss_pc_q     <= miss_pc_d;
            redirect_pc_q <= redirect_pc_d;
            byp_data_q    <= byp_data_d;
        end
    end

endmodule
